// File: rtl/jtkiwi_objbuf_pkg.sv
// Shared sizing and FSM state encoding for the Kiwi object line buffer.
package jtkiwi_objbuf_pkg;

    localparam int OBJ_AW = 9;
    localparam int OBJ_DW = 9;

    typedef enum logic {
        ST_CLR = 1'b0,
        ST_RUN = 1'b1
    } objbuf_state_t;

endpackage

// File: rtl/jtkiwi_objbuf_bank.sv
// One line-buffer bank: single write port, single registered read port.
module jtkiwi_objbuf_bank #(
    parameter int AW = 9,
    parameter int DW = 9
)(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // rd_data only moves on a read so the pixel holds between pixel enables
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/jtkiwi_objbuf.sv
// Double-buffered object line buffer: drawer fills one bank while the other
// is displayed and cleared behind the read; banks swap on each hs rising edge.
module jtkiwi_objbuf
    import jtkiwi_objbuf_pkg::*;
#(
    parameter int AW = OBJ_AW,
    parameter int DW = OBJ_DW
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_cen,
    input  logic          hs,
    input  logic          LHBL,
    input  logic [AW-1:0] hdump,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          line_start,
    output logic [DW-1:0] obj_pxl
);

    localparam logic [3:0] PEN_CLEAR = 4'd0;

    objbuf_state_t state, state_nx;
    logic [AW-1:0] clr_addr;
    logic          run;
    logic          bank;
    logic          hs_l;
    logic          hs_rise;
    logic          draw_we;
    logic          rd_fire;
    logic          clr_pend;
    logic [AW-1:0] clr_wa;
    logic          rd_bank;
    logic          pxl_ok;
    logic [1:0]    bank_we;
    logic [AW-1:0] bank_wa [2];
    logic [DW-1:0] bank_wd [2];
    logic [DW-1:0] bank_rd [2];

    assign run     = (state == ST_RUN);
    assign hs_rise = hs & ~hs_l;
    assign draw_we = run & wr_en & (wr_data[3:0] != PEN_CLEAR);
    assign rd_fire = run & pxl_cen;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_CLR;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        case (state)
            ST_CLR: begin
                busy = 1'b1;
                if (clr_addr == {AW{1'b1}}) state_nx = ST_RUN;
            end
            default: state_nx = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_addr   <= '0;
            bank       <= 1'b0;
            hs_l       <= 1'b0;
            line_start <= 1'b0;
            clr_pend   <= 1'b0;
            clr_wa     <= '0;
            rd_bank    <= 1'b0;
            pxl_ok     <= 1'b0;
        end else begin
            hs_l       <= hs;
            clr_addr   <= run ? '0 : clr_addr + 1'b1;
            line_start <= run & hs_rise;
            if (run && hs_rise) bank <= ~bank;
            // the read latches the pre-swap display bank; the clear follows it
            clr_pend <= rd_fire;
            if (rd_fire) begin
                clr_wa  <= hdump;
                rd_bank <= ~bank;
                pxl_ok  <= LHBL;
            end
            if (!run) pxl_ok <= 1'b0;
        end
    end

    // Drawer wins the port if a clear-behind lands on the freshly swapped draw bank
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_we[b] = 1'b0;
            bank_wa[b] = clr_wa;
            bank_wd[b] = '0;
            if (!run) begin
                bank_we[b] = 1'b1;
                bank_wa[b] = clr_addr;
            end else if (draw_we && bank == 1'(b)) begin
                bank_we[b] = 1'b1;
                bank_wa[b] = wr_addr;
                bank_wd[b] = wr_data;
            end else if (clr_pend && rd_bank == 1'(b)) begin
                bank_we[b] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        jtkiwi_objbuf_bank #(
            .AW(AW),
            .DW(DW)
        ) u_bank (
            .clk     (clk),
            .we      (bank_we[g]),
            .wr_addr (bank_wa[g]),
            .wr_data (bank_wd[g]),
            .rd_en   (rd_fire),
            .rd_addr (hdump),
            .rd_data (bank_rd[g])
        );
    end

    assign obj_pxl = pxl_ok ? bank_rd[rd_bank] : '0;

endmodule

// File: tb/tb_jtkiwi_objbuf.sv
// Scoreboard bench for jtkiwi_objbuf: reads push expected pixels, a monitor pops and compares.
module tb_jtkiwi_objbuf;

    localparam int AW = 9;
    localparam int DW = 9;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] v;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pxl_cen = 1'b0;
    logic          hs = 1'b0;
    logic          LHBL = 1'b1;
    logic [AW-1:0] hdump = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          busy;
    logic          line_start;
    logic [DW-1:0] obj_pxl;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [DW-1:0] mdl [2][512];
    logic bank_m = 1'b0;
    logic chk_next = 1'b0;

    always #5 clk = ~clk;

    jtkiwi_objbuf #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .pxl_cen    (pxl_cen),
        .hs         (hs),
        .LHBL       (LHBL),
        .hdump      (hdump),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .line_start (line_start),
        .obj_pxl    (obj_pxl)
    );

    always @(posedge clk) chk_next <= pxl_cen;

    always @(negedge clk) begin
        if (chk_next) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL obj_pxl: output with no expected entry, got %h", obj_pxl);
            end else begin
                mon_e = exp_q.pop_front();
                if (obj_pxl !== mon_e.v) begin
                    errors++;
                    $display("FAIL obj_pxl@%0d: got %h, want %h", mon_e.a, obj_pxl, mon_e.v);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic clear_model();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 512; i++)
                mdl[b][i] = '0;
    endtask

    task automatic do_reset();
        int n;
        int ls;
        @(negedge clk);
        rst = 1'b1; pxl_cen = 1'b0; wr_en = 1'b0; hs = 1'b0;
        repeat (3) @(negedge clk);
        check("rst busy", int'(busy), 1);
        check("rst obj_pxl", int'(obj_pxl), 0);
        check("rst line_start", int'(line_start), 0);
        rst = 1'b0;
        n = 0;
        ls = 0;
        while (busy && n < 2000) begin
            n++;
            if (line_start) ls++;
            @(negedge clk);
        end
        check("clr cycles", n, 512);
        check("clr line_start", ls, 0);
        bank_m = 1'b0;
        clear_model();
    endtask

    task automatic push_read(input int a, input logic lhbl);
        exp_t e;
        e.a = AW'(a);
        e.v = lhbl ? mdl[!bank_m][a] : '0;
        exp_q.push_back(e);
        mdl[!bank_m][a] = '0;
    endtask

    task automatic sweep(input int lo, input int hi, input int blank_lo = -1, input int blank_hi = -1);
        for (int a = lo; a <= hi; a++) begin
            @(negedge clk);
            hdump   = AW'(a);
            LHBL    = !(a >= blank_lo && a <= blank_hi);
            pxl_cen = 1'b1;
            push_read(a, LHBL);
            @(negedge clk);
            pxl_cen = 1'b0;
            LHBL    = 1'b1;
        end
    endtask

    task automatic draw(input int a, input int d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(d);
        if (d[3:0] != 4'd0) mdl[bank_m][a] = DW'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic ls_window(input string name);
        int ls;
        ls = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pxl_cen = 1'b0;
            wr_en   = 1'b0;
            if (line_start) ls++;
        end
        hs = 1'b0;
        check(name, ls, 1);
    endtask

    task automatic swap(input string name);
        @(negedge clk);
        hs = 1'b1;
        bank_m = !bank_m;
        ls_window(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        clear_model();
        do_reset();
        sweep(0, 511);
        swap("line_start init");
        sweep(0, 511);

        draw(10, 'h1A3);
        swap("line_start draw");
        sweep(0, 383);

        swap("line_start a");
        swap("line_start b");
        sweep(0, 383);

        draw(20, 'h1A3);
        draw(20, 'h150);
        swap("line_start ovr1");
        sweep(0, 383);
        draw(20, 'h055);
        swap("line_start ovr2");
        sweep(0, 383);

        draw(30, 'h1B7);
        swap("line_start blank");
        sweep(0, 383, 30, 30);
        swap("line_start c");
        swap("line_start d");
        sweep(0, 383);

        // hs edge, read and write all on one clk
        draw(40, 'h1C9);
        @(negedge clk);
        hs = 1'b1; pxl_cen = 1'b1; hdump = AW'(40); LHBL = 1'b1;
        wr_en = 1'b1; wr_addr = AW'(5); wr_data = DW'('h12F);
        push_read(40, 1'b1);
        mdl[bank_m][5] = DW'('h12F);
        bank_m = !bank_m;
        ls_window("line_start corner");
        sweep(40, 40);
        sweep(0, 383);

        // reset partway through a line
        draw(50, 'h1DD);
        swap("line_start pre-rst");
        draw(60, 'h1EE);
        sweep(0, 30);
        do_reset();
        sweep(0, 511);
        swap("line_start post-rst");
        sweep(0, 511);

        @(negedge clk);
        check("queue drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
